// File: rtl/dac_module_9764_if.sv
// Playback DAC bus: control/status, FIFO read port and DAC pins grouped together.
// master = control logic + FIFO side, slave = the DAC playback engine.
interface dac_module_9764_if #(
  parameter int DAC_W  = 14,
  parameter int FIFO_W = 16
);
  logic [31:0]       dac_sample_freq;
  logic [15:0]       dac_sample_num;
  logic              dac_start;
  logic              dac_abort;
  logic              dac_fifo_empty;
  logic [FIFO_W-1:0] dac_fifo_q;
  logic              dac_fifo_rdreq;
  logic              dac_clk;
  logic [DAC_W-1:0]  dac_data;
  logic              dac_busy;
  logic              dac_done;
  logic              dac_underflow;

  modport master (
    output dac_sample_freq, dac_sample_num, dac_start, dac_abort,
    output dac_fifo_empty, dac_fifo_q,
    input  dac_fifo_rdreq, dac_clk, dac_data, dac_busy, dac_done, dac_underflow
  );

  modport slave (
    input  dac_sample_freq, dac_sample_num, dac_start, dac_abort,
    input  dac_fifo_empty, dac_fifo_q,
    output dac_fifo_rdreq, dac_clk, dac_data, dac_busy, dac_done, dac_underflow
  );
endinterface

// File: rtl/dac_module_9764.sv
// Burst playback engine: pulls words from a non-showahead FIFO and drives a parallel DAC
// at a rate set by a 32-bit phase accumulator; the DAC clock is the accumulator MSB.
module dac_module_9764 #(
  parameter int               DAC_W    = 14,
  parameter int               FIFO_W   = 16,
  parameter logic [DAC_W-1:0] MIDSCALE = {1'b1, {(DAC_W-1){1'b0}}}
) (
  input  logic clk_256M,
  input  logic rst,
  dac_module_9764_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  localparam logic [31:0] INC_MAX = 32'h8000_0000;

  state_t           state_reg, state_next;
  logic [31:0]      acc_reg, inc_reg;
  logic [32:0]      acc_sum;
  logic             tick;
  logic [15:0]      num_reg, fetched_reg, sent_reg;
  logic [DAC_W-1:0] hold_reg, dac_data_reg, q_low;
  logic             hold_valid_reg, rd_pending_reg, done_reg, underflow_reg;
  logic             start_ok, consume, last_sample, load, rdreq, busy;

  genvar gi;
  generate
    for (gi = 0; gi < DAC_W; gi++) begin : g_q_low
      assign q_low[gi] = bus.dac_fifo_q[gi];
    end
    if (FIFO_W > DAC_W) begin : g_q_high
      logic unused_q_high;
      assign unused_q_high = ^bus.dac_fifo_q[FIFO_W-1:DAC_W];
    end
  endgenerate

  assign acc_sum     = {1'b0, acc_reg} + {1'b0, inc_reg};
  assign tick        = acc_sum[32];
  assign start_ok    = bus.dac_start && !bus.dac_abort && (state_reg == S_IDLE)
                       && (bus.dac_sample_num != 16'd0);
  assign consume     = (state_reg == S_RUN) && tick && hold_valid_reg;
  assign last_sample = consume && ((sent_reg + 16'd1) == num_reg);
  assign load        = (state_reg != S_IDLE) && rd_pending_reg;

  always_ff @(posedge clk_256M) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.dac_abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (start_ok)       state_next = S_PRIME;
        S_PRIME: if (hold_valid_reg) state_next = S_RUN;
        S_RUN:   if (last_sample)    state_next = S_IDLE;
        default:                     state_next = S_IDLE;
      endcase
    end
  end

  // The next read may issue on the tick that empties hold, so back-to-back
  // ticks two cycles apart are still fed without underflow.
  always_comb begin
    busy  = (state_reg == S_PRIME) || (state_reg == S_RUN);
    rdreq = busy && (!hold_valid_reg || consume) && !rd_pending_reg
            && (fetched_reg < num_reg) && !bus.dac_fifo_empty;
  end

  always_ff @(posedge clk_256M) begin
    if (rst) begin
      acc_reg        <= 32'd0;
      inc_reg        <= 32'd0;
      num_reg        <= 16'd0;
      fetched_reg    <= 16'd0;
      sent_reg       <= 16'd0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      rd_pending_reg <= 1'b0;
      dac_data_reg   <= MIDSCALE;
      done_reg       <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      rd_pending_reg <= rdreq;
      done_reg       <= 1'b0;
      if (start_ok || (state_reg == S_PRIME)) acc_reg <= 32'd0;
      else                                    acc_reg <= acc_sum[31:0];

      if (start_ok) begin
        num_reg        <= bus.dac_sample_num;
        inc_reg        <= (bus.dac_sample_freq > INC_MAX) ? INC_MAX : bus.dac_sample_freq;
        fetched_reg    <= 16'd0;
        sent_reg       <= 16'd0;
        underflow_reg  <= 1'b0;
        hold_valid_reg <= 1'b0;
      end

      if (bus.dac_abort) begin
        dac_data_reg   <= MIDSCALE;
        hold_valid_reg <= 1'b0;
      end else begin
        // A word landing after an abort finds the engine idle and is dropped.
        if (load) begin
          hold_reg       <= q_low;
          hold_valid_reg <= 1'b1;
          fetched_reg    <= fetched_reg + 16'd1;
        end else if (consume) begin
          hold_valid_reg <= 1'b0;
        end

        if (consume) begin
          dac_data_reg <= hold_reg;
          sent_reg     <= sent_reg + 16'd1;
          if (last_sample) done_reg <= 1'b1;
        end else if ((state_reg == S_RUN) && tick) begin
          underflow_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.dac_fifo_rdreq = rdreq;
  assign bus.dac_clk        = acc_reg[31];
  assign bus.dac_data       = dac_data_reg;
  assign bus.dac_busy       = busy;
  assign bus.dac_done       = done_reg;
  assign bus.dac_underflow  = underflow_reg;
endmodule
